result_uart_tx: RTL
===================

// Module: result_uart_tx
// PURPOSE
//  Sends inference results to the host over the ULX3S FTDI UART, in the opposite direction to the GPIO beam/grid input.
//  On each rising edge of the engine's done output, captures beam_out and split_count.
//  Sends the captured values as one framed 8N1 byte burst on tx. Sits beside inference_engine in the board top.
// PARAMETERS
//  CLK_HZ        25_000_000  system clock frequency (ULX3S oscillator, no PLL)
//  BAUD          115_200     line rate
//  CLKS_PER_BIT  CLK_HZ/BAUD bit period in clocks (integer divide; 217 at defaults)
// PORTS
//  clock        in   1   system clock; all logic on rising edge
//  clear_n      in   1   asynchronous active-low reset
//  done         in   1   engine done level; a frame is triggered on its 0->1 edge
//  beam_out     in   16  engine beam result, sampled on the trigger cycle
//  split_count  in   8   engine split count, sampled on the trigger cycle
//  tx           out  1   UART serial out, idle high
//  busy         out  1   frame in progress
//  overrun      out  1   sticky: trigger dropped because busy
// BEHAVIOUR
//  Reset (async, clear_n=0): tx=1, busy=0, overrun=0, done_q=0, FSM=IDLE, counters=0; tx forced high immediately, mid-frame included.
//  Edge detect: trig = done & ~done_q; done_q registered each clock. done is on the same clock domain, so no synchroniser.
//  Accept: trig in cycle N with busy=0 -> latch {beam_out,split_count}, busy=1 from N+1, tx start bit low from N+1.
//  Drop: trig while busy=1, including the final stop-bit cycle -> frame unaffected, overrun=1 until reset.
//  Frame bytes in order: 0xA5 sync, beam_out[15:8], beam_out[7:0], split_count, then checksum byte if CHECKSUM_EN is defined.
//  Byte format 8N1: start(0), d0..d7 LSB first, stop(1). Each bit is held exactly CLKS_PER_BIT clocks.
//  Bytes are back-to-back: next start bit immediately follows the previous stop bit, with no idle gap.
//  FSM states:
//    IDLE  -> START on accept
//    START -> DATA after one bit period
//    DATA  -> STOP after 8 bit periods
//    STOP  -> START if bytes remain, else IDLE
//  busy=0 in the first cycle back in IDLE. tx=1 in IDLE and STOP.
//  Counters: baud counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Bit index 0..7 (3b). Byte index 0..FRAME_LEN-1 (3b).
//  Frame length in clocks = FRAME_LEN*10*CLKS_PER_BIT.
//  Held-high done triggers only once. done must return to 0 before the next frame can trigger.
//  Input changes after the trigger cycle do not affect a frame in progress.
// CONFIGURATION
//  RESULT_UART_CHECKSUM_EN defined: FRAME_LEN=5; byte 4 = beam_out[15:8]^beam_out[7:0]^split_count.
//  RESULT_UART_CHECKSUM_EN undefined: FRAME_LEN=4; no checksum logic is synthesised.
// STRUCTURE
//  Package result_uart_pkg:
//   - SYNC_BYTE=8'hA5
//   - FRAME_LEN (macro-dependent)
//   - tx_state_t enum {IDLE,START,DATA,STOP}
//   - function frame_byte(idx, beam, split) returning the byte for index idx
//  Sub-module uart_tx_byte: 8N1 serialiser with load/ready handshake. ready=1 in the cycle its stop bit ends, so back-to-back loads need no gap.
//  Top FSM in this module: edge detect, capture, byte sequencing and overrun flag.
// TESTING
//  1. Reset, then done 0->1 with beam_out=16'h1234, split_count=8'h05.
//     -> tx decodes A5 12 34 05 (+23 with CHECKSUM_EN).
//     -> busy high for 8680 clocks (10850 with CHECKSUM_EN); tx low from the cycle after the edge.
//  2. Hold done high for 20000 clocks -> exactly one frame sent; overrun stays 0.
//  3. Pulse done low then high again 1000 clocks into a frame.
//     -> frame bytes unchanged, no second frame, overrun=1.
//  4. Toggle done so its edge lands 1 clock after busy falls.
//     -> second frame starts; no idle gap beyond that cycle; overrun=0.
//  5. Drive clear_n=0 mid-DATA of byte 2 -> tx=1 and busy=0 without waiting for a clock edge.
//     Then release clear_n and trigger -> a full clean frame follows.
//  6. Change beam_out to 16'hFFFF one cycle after an accepted trigger of 16'h00F0.
//     -> bytes sent are 00 F0, not FF FF.
//  Check every bit width is 217 clocks (±0) at default parameters.

Source files
------------

// File: rtl/result_uart_pkg.sv
// Shared constants, state type and frame layout for result_uart_tx.
// Define RESULT_UART_CHECKSUM_EN to append an XOR checksum byte.
package result_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef RESULT_UART_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [15:0] beam,
    input logic [7:0]  split
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = beam[15:8];
      3'd2:    b = beam[7:0];
      3'd3:    b = split;
`ifdef RESULT_UART_CHECKSUM_EN
      3'd4:    b = beam[15:8] ^ beam[7:0] ^ split;
`endif
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; ready pulses in the last stop-bit clock so
// a load in that same cycle chains the next byte with no idle gap.
module uart_tx_byte
  import result_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       ready_o
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_MAX);
  assign ready_o = (state_q == STOP) && bit_end;
  assign tx_o    = tx_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      baud_q <= bit_end ? '0 : baud_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (load_i) begin
            state_q <= START;
            tx_q    <= 1'b0;
            shift_q <= data_i;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (load_i) begin
              state_q <= START;
              tx_q    <= 1'b0;
              shift_q <= data_i;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Captures beam/split results on each done rising edge and sends them
// as one back-to-back 8N1 burst; optional RESULT_UART_CHECKSUM_EN.
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        done,
  input  logic [15:0] beam_out,
  input  logic [7:0]  split_count,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  logic        done_q;
  logic        busy_q;
  logic        ovr_q;
  logic [2:0]  idx_q;
  logic [15:0] beam_q;
  logic [7:0]  split_q;

  logic       trig;
  logic       accept;
  logic       ready;
  logic       last;
  logic       load;
  logic [7:0] load_byte;

  assign trig   = done & ~done_q;
  assign accept = trig & ~busy_q;
  assign last   = (idx_q == LAST_IDX);
  assign load   = accept | (busy_q & ready & ~last);

  // First byte comes straight from the constant; later ones from the capture.
  assign load_byte = accept ? SYNC_BYTE :
    frame_byte(idx_q + 3'd1, beam_q, split_q);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      idx_q   <= '0;
      beam_q  <= '0;
      split_q <= '0;
    end else begin
      done_q <= done;
      if (accept) begin
        busy_q  <= 1'b1;
        idx_q   <= '0;
        beam_q  <= beam_out;
        split_q <= split_count;
      end else if (busy_q && ready) begin
        if (last) busy_q <= 1'b0;
        else      idx_q  <= idx_q + 3'd1;
      end
      if (trig && busy_q) ovr_q <= 1'b1;
    end
  end

  assign busy    = busy_q;
  assign overrun = ovr_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk_i  (clock),
    .rst_n_i(clear_n),
    .load_i (load),
    .data_i (load_byte),
    .tx_o   (tx),
    .ready_o(ready)
  );

endmodule
